// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous square wave in clk_in cycles,
// with lock detection on successive periods and loss-of-signal timeout.
module clk_period_meter #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned TIMEOUT    = 1000000,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned TOLERANCE  = 1
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             sig_in,
   output logic [WIDTH-1:0] period_out,
   output logic [WIDTH-1:0] high_out,
   output logic             valid_out,
   output logic             locked_out,
   output logic             timeout_out
);

   localparam int unsigned MW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam logic [WIDTH-1:0] TO_C  = WIDTH'(TIMEOUT);
   localparam logic [WIDTH-1:0] TOL_C = WIDTH'(TOLERANCE);
   localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);
   localparam logic [MW-1:0]    LC_C  = MW'(LOCK_COUNT);

   typedef enum logic {IDLE, ARMED} state_e;

   state_e           state_q, state_d;
   logic             sync1_q, sync2_q, prev_q;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hl_q, hl_d;
   logic [WIDTH-1:0] prevp_q, prevp_d;
   logic [WIDTH-1:0] per_q, per_d;
   logic [WIDTH-1:0] high_q, high_d;
   logic [MW-1:0]    mc_q, mc_d;
   logic             first_q, first_d;
   logic             valid_q, valid_d;
   logic             lock_q, lock_d;
   logic             to_q, to_d;
   logic             rise, fall;
   logic [WIDTH-1:0] diff;

   assign rise = sync2_q & ~prev_q;
   assign fall = ~sync2_q & prev_q;
   assign diff = (cnt_q >= prevp_q) ? (cnt_q - prevp_q) : (prevp_q - cnt_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hl_d    = hl_q;
      prevp_d = prevp_q;
      per_d   = per_q;
      high_d  = high_q;
      mc_d    = mc_q;
      first_d = first_q;
      valid_d = 1'b0;
      lock_d  = lock_q;
      to_d    = to_q;
      case (state_q)
         IDLE: begin
            if (rise) begin
               state_d = ARMED;
               cnt_d   = ONE_C;
               hl_d    = '0;
               to_d    = 1'b0;
               first_d = 1'b1;
            end
         end
         ARMED: begin
            // a rise on the timeout cycle still publishes; timeout only when no rise
            if (rise) begin
               per_d   = cnt_q;
               high_d  = hl_q;
               valid_d = 1'b1;
               hl_d    = '0;
               cnt_d   = ONE_C;
               prevp_d = cnt_q;
               first_d = 1'b0;
               if (first_q)           mc_d = '0;
               else if (diff <= TOL_C) mc_d = (mc_q == LC_C) ? mc_q : mc_q + MW'(1);
               else                   mc_d = '0;
               lock_d = (mc_d == LC_C);
            end else if (cnt_q == TO_C) begin
               state_d = IDLE;
               to_d    = 1'b1;
               lock_d  = 1'b0;
               mc_d    = '0;
            end else begin
               cnt_d = cnt_q + ONE_C;
               if (fall) hl_d = cnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         cnt_q   <= '0;
         hl_q    <= '0;
         prevp_q <= '0;
         per_q   <= '0;
         high_q  <= '0;
         mc_q    <= '0;
         first_q <= 1'b0;
         valid_q <= 1'b0;
         lock_q  <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sig_in;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         hl_q    <= hl_d;
         prevp_q <= prevp_d;
         per_q   <= per_d;
         high_q  <= high_d;
         mc_q    <= mc_d;
         first_q <= first_d;
         valid_q <= valid_d;
         lock_q  <= lock_d;
         to_q    <= to_d;
      end
   end

   assign period_out  = per_q;
   assign high_out    = high_q;
   assign valid_out   = valid_q;
   assign locked_out  = lock_q;
   assign timeout_out = to_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Randomized bench for clk_period_meter against an edge-timestamp reference model.
module tb_clk_period_meter;

   localparam int W   = 16;
   localparam int TO  = 50;
   localparam int LC  = 4;
   localparam int TOL = 1;

   logic         clk_in = 1'b0;
   logic         rst_n  = 1'b0;
   logic         sig_in = 1'b0;
   logic [W-1:0] period_out, high_out;
   logic         valid_out, locked_out, timeout_out;

   int total = 0;
   int bad   = 0;

   // reference model state: timestamps of edges, not counters
   int  m_edge, m_t0, m_hi, m_prevp, m_mc;
   bit  m_armed, m_first;
   bit  h1, h2, h3;
   int  e_period, e_high;
   bit  e_valid, e_lock, e_to;

   clk_period_meter #(.WIDTH(W), .TIMEOUT(TO), .LOCK_COUNT(LC), .TOLERANCE(TOL)) dut (
      .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
      .period_out(period_out), .high_out(high_out), .valid_out(valid_out),
      .locked_out(locked_out), .timeout_out(timeout_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
      end
   endtask

   task automatic m_reset();
      m_edge = 0; m_t0 = 0; m_hi = 0; m_prevp = 0; m_mc = 0;
      m_armed = 0; m_first = 0;
      h1 = 0; h2 = 0; h3 = 0;
      e_period = 0; e_high = 0; e_valid = 0; e_lock = 0; e_to = 0;
   endtask

   // edge seen by the meter at this clock is the stimulus transition 2..3 samples back
   task automatic m_step(input bit s);
      bit r, f;
      int p, d;
      m_edge++;
      r = h2 & ~h3;
      f = ~h2 & h3;
      h3 = h2; h2 = h1; h1 = s;
      e_valid = 0;
      if (!m_armed) begin
         if (r) begin
            m_armed = 1; m_t0 = m_edge; m_hi = 0; m_first = 1; e_to = 0;
         end
      end else if (r) begin
         p = m_edge - m_t0;
         e_period = p; e_high = m_hi; e_valid = 1;
         d = (p > m_prevp) ? p - m_prevp : m_prevp - p;
         if (m_first)       m_mc = 0;
         else if (d <= TOL) m_mc = (m_mc < LC) ? m_mc + 1 : LC;
         else               m_mc = 0;
         e_lock = (m_mc == LC);
         m_prevp = p; m_first = 0; m_t0 = m_edge; m_hi = 0;
      end else if (m_edge - m_t0 == TO) begin
         m_armed = 0; e_to = 1; e_lock = 0; m_mc = 0;
      end else if (f) begin
         m_hi = m_edge - m_t0;
      end
   endtask

   task automatic check_all();
      chk("valid",   32'(valid_out),   32'(e_valid));
      chk("period",  32'(period_out),  32'(e_period));
      chk("high",    32'(high_out),    32'(e_high));
      chk("locked",  32'(locked_out),  32'(e_lock));
      chk("timeout", 32'(timeout_out), 32'(e_to));
   endtask

   task automatic tick(input logic s);
      sig_in = s;
      @(posedge clk_in);
      #1;
      if (!rst_n) m_reset();
      else        m_step(s);
      check_all();
   endtask

   task automatic wave(input int p, input int h, input int n);
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < p; j++) tick(j < h);
      end
   endtask

   task automatic async_reset(input logic s);
      #2;
      rst_n = 1'b0;
      #1;
      m_reset();
      check_all();
      tick(s);
      tick(s);
      rst_n = 1'b1;
   endtask

   initial begin
      int base, p, h;
      m_reset();
      tick(0); tick(0);
      rst_n = 1'b1;
      check_all();

      wave(4, 2, 10);
      wave(10, 3, 8);
      wave(12, 5, 8);
      // tolerance: 30,31,30,29,30 locks; 33 breaks it
      wave(30, 10, 1); wave(31, 10, 1); wave(30, 10, 1); wave(29, 10, 1);
      wave(30, 10, 1); wave(30, 10, 1); wave(33, 10, 1); wave(33, 10, 1);
      // lock at period 8, then loss of signal and recovery
      wave(8, 4, 8);
      for (int j = 0; j < 70; j++) tick(0);
      wave(8, 4, 4);
      // period exactly TIMEOUT (rise wins) and one beyond it
      wave(TO, 7, 3);
      wave(TO + 1, 7, 3);
      // reset mid-period while locked
      wave(6, 3, 8);
      tick(1); tick(1);
      async_reset(0);
      wave(6, 3, 4);
      // constant high through reset
      sig_in = 1'b1;
      async_reset(1);
      for (int j = 0; j < TO + 10; j++) tick(1);
      wave(5, 2, 3);
      // randomized groups of jittered periods
      for (int g = 0; g < 12; g++) begin
         base = $urandom_range(3, 45);
         for (int k = 0; k < 7; k++) begin
            p = base + $urandom_range(0, 2);
            h = $urandom_range(1, p - 1);
            wave(p, h, 1);
         end
      end
      for (int k = 0; k < 20; k++) begin
         p = $urandom_range(2, 60);
         h = $urandom_range(1, p - 1);
         wave(p, h, 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clk_period_meter.md
Name: clk_period_meter

Overview:
Measures an incoming square wave (typically a divided clock) against the system clock. The input is synchronised and edge-detected, and clk_in cycles are counted between consecutive rising edges. Each completed period publishes the period and high time with a one-cycle valid strobe. It also reports frequency lock and loss-of-signal. This is the receive/verify side for divided-clock outputs, used for board bring-up and for self-check of clock-divided signals.

Parameters:
WIDTH, 32, width of counter, period_out and high_out
TIMEOUT, 1000000, clk_in cycles without a detected rising edge before loss-of-signal; legal range 2..2^WIDTH-1
LOCK_COUNT, 4, consecutive matching period pairs required for lock; must be >= 1
TOLERANCE, 1, maximum absolute difference (cycles) between successive periods counted as a match

Ports:
clk_in  input  1  system clock; all logic on posedge
rst_n  input  1  reset, asynchronous, active-low
sig_in  input  1  asynchronous square wave to measure
period_out  output  WIDTH  last measured period, in clk_in cycles
high_out  output  WIDTH  high time of that period, in clk_in cycles; 0 if no falling edge was seen
valid_out  output  1  one-cycle pulse when period_out/high_out update
locked_out  output  1  period stable within TOLERANCE for LOCK_COUNT consecutive pairs
timeout_out  output  1  level; no rising edge for TIMEOUT cycles

Behaviour:
- Reset, asynchronous on rst_n low, effective immediately:
  - period_out=0, high_out=0, valid_out=0, locked_out=0, timeout_out=0.
  - Synchroniser flops=0, cnt=0, match_cnt=0, state=IDLE.
- Input path: 2-flop synchroniser, then a registered previous-sample flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Fixed latency of 3 clk_in cycles from sig_in to rise/fall; it cancels in all measurements.
- sig_in high at reset release produces a rise on the 3rd cycle. This is legal and arms the meter.
- Counter cnt:
  - Set to 1 on rise.
  - Otherwise increments by 1 each cycle in ARMED.
  - Held in IDLE.
- State IDLE: waiting for a reference edge.
  - rise -> ARMED, cnt=1, high_latch=0, timeout_out cleared.
  - No valid_out is produced on this edge.
- State ARMED:
  - fall -> high_latch <= cnt.
  - rise -> period_out <= cnt, high_out <= high_latch, valid_out=1 on the next cycle, high_latch <= 0, cnt <= 1, prev_period <= cnt.
  - Two rises N cycles apart yield period_out=N.
  - cnt reaches TIMEOUT with no rise -> IDLE, timeout_out=1, locked_out=0, match_cnt=0.
  - period_out and high_out keep their last values.
- Simultaneous rise and timeout in the same cycle: rise wins; the measurement is published and there is no timeout.
- Lock, evaluated on each published measurement:
  - First measurement after IDLE: no comparison; match_cnt=0.
  - Otherwise, |cnt - prev_period| <= TOLERANCE -> match_cnt increments, saturating at LOCK_COUNT.
  - Otherwise match_cnt=0 and locked_out=0.
  - locked_out = (match_cnt == LOCK_COUNT), registered, updating in the same cycle as valid_out.
- Difference arithmetic is unsigned, WIDTH bits: compute the larger minus the smaller; no wrap.
- Minimum resolvable period is 2 cycles (sig_in toggling at clk_in/2). Faster inputs alias; no requirement applies.
- Short pulses missed by the synchroniser produce no edge. A period whose falling edge is missed reports high_out=0.

Test Plan:
- Reset, then sig_in square wave period 4, high 2 -> first rise arms with no valid; then valid_out pulses every 4 cycles with period_out=4, high_out=2; locked_out=1 coincident with the 5th valid.
- Period 10, high 3 -> period_out=10, high_out=3 each valid. Switch to period 12 -> first valid shows 12, locked_out drops that cycle and relocks after 4 further matching periods.
- TOLERANCE=1, periods 100,101,100,99,100 -> locked_out=1 after the 5th valid. Next period 103 -> locked_out=0 with that valid.
- sig_in held low after lock at period 8, TIMEOUT=50 -> timeout_out=1 and locked_out=0 exactly 50 cycles after the last rise; no valid_out. Resume toggling -> timeout_out clears on the first rise, no valid on it, first valid at the second rise.
- rst_n pulsed low mid-period while locked -> all outputs 0 immediately without a clock edge. After release, the first rise re-arms with no valid.
- sig_in constant high through reset -> a single rise arms the meter, then timeout_out=1 after TIMEOUT cycles; valid_out never asserts.
